pipe_stage: RTL and testbench

PIPE_STAGE -- requirements
Module: pipe_stage

---
 rtl/pipe_pkg.sv | 25 ++
 rtl/pipe_fwd_mux.sv | 21 ++
 rtl/pipe_stage.sv | 181 ++++++++++++++++++
 tb/tb_pipe_stage.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipe_stage skid-buffer slice.
// Holds the occupancy state enum, default width constants and the zero
// bubble constant used to blank control fields when no entry is valid.
package pipe_pkg;

    // Occupancy of the two-entry buffer: nothing held, main only, main + skid.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Default widths for the pipeline payload.
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_CTRL_W  = 16;
    localparam int DEF_NUM_OPS = 2;
    localparam int DEF_REG_W   = 5;

    // Widest field a bubble may need to blank; modules slice what they need.
    localparam int BUBBLE_W = 256;

    // All-zero bubble pattern; a blank control bundle is a harmless NOP downstream.
    localparam logic [BUBBLE_W-1:0] BUBBLE = '0;

endpackage

// File: rtl/pipe_fwd_mux.sv
// pipe_fwd_mux: forward select for a single source operand.
// Chooses the forwarded writeback value over the register-file operand
// when the operand's forward select is set. Purely combinational; the
// caller registers the result only on accept.
module pipe_fwd_mux
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              sel,
    input  logic [DATA_W-1:0] op,
    input  logic [DATA_W-1:0] fwd_data,
    output logic [DATA_W-1:0] cap
);

    // Forwarded value wins whenever the select bit is set.
    always_comb begin
        cap = sel ? fwd_data : op;
    end

endmodule

// File: rtl/pipe_stage.sv
// pipe_stage: two-entry skid buffer pipeline register (main + skid).
// The main entry drives out_* directly; the skid entry absorbs one extra
// instruction so in_ready can be fully registered with no combinational
// path from out_ready. Define PIPE_STAGE_FWD_EN to add per-operand
// forwarding muxes (fwd_sel/fwd_data ports) sampled at accept time.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CTRL_W  = DEF_CTRL_W,
    parameter int NUM_OPS = DEF_NUM_OPS,
    parameter int REG_W   = DEF_REG_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [CTRL_W-1:0]          in_ctrl,
    input  logic [NUM_OPS*DATA_W-1:0]  in_ops,
    input  logic [NUM_OPS*REG_W-1:0]   in_regs,
    input  logic [REG_W-1:0]           in_write_reg,
    input  logic [DATA_W-1:0]          in_pc,
    input  logic [DATA_W-1:0]          in_next_pc,
    input  logic                       flush,
`ifdef PIPE_STAGE_FWD_EN
    input  logic [NUM_OPS-1:0]         fwd_sel,
    input  logic [DATA_W-1:0]          fwd_data,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CTRL_W-1:0]          out_ctrl,
    output logic [NUM_OPS*DATA_W-1:0]  out_ops,
    output logic [NUM_OPS*REG_W-1:0]   out_regs,
    output logic [REG_W-1:0]           out_write_reg,
    output logic [DATA_W-1:0]          out_pc,
    output logic [DATA_W-1:0]          out_next_pc
);

    localparam logic [CTRL_W-1:0]        CTRL_BUBBLE = BUBBLE[CTRL_W-1:0];
    localparam logic [NUM_OPS*REG_W-1:0] REGS_BUBBLE = BUBBLE[NUM_OPS*REG_W-1:0];
    localparam logic [REG_W-1:0]         WR_BUBBLE   = BUBBLE[REG_W-1:0];

    state_t                      state;

    logic [CTRL_W-1:0]           skid_ctrl;
    logic [NUM_OPS*DATA_W-1:0]   skid_ops;
    logic [NUM_OPS*REG_W-1:0]    skid_regs;
    logic [REG_W-1:0]            skid_write_reg;
    logic [DATA_W-1:0]           skid_pc;
    logic [DATA_W-1:0]           skid_next_pc;

    logic [NUM_OPS*DATA_W-1:0]   cap_ops;
    logic                        accept;
    logic                        release_out;

    // Handshake qualifiers; in_ready and out_valid are both registered.
    always_comb begin
        accept      = in_valid & in_ready;
        release_out = out_valid & out_ready;
    end

`ifdef PIPE_STAGE_FWD_EN
    // One forward mux per source operand; only the accept-time value is kept.
    for (genvar i = 0; i < NUM_OPS; i++) begin : g_fwd
        pipe_fwd_mux #(
            .DATA_W(DATA_W)
        ) u_fwd_mux (
            .sel      (fwd_sel[i]),
            .op       (in_ops[i*DATA_W +: DATA_W]),
            .fwd_data (fwd_data),
            .cap      (cap_ops[i*DATA_W +: DATA_W])
        );
    end
`else
    // Without forwarding the operands are captured exactly as presented.
    always_comb begin
        cap_ops = in_ops;
    end
`endif

    // Occupancy FSM plus main/skid payload; flush outranks every other event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= EMPTY;
            out_valid      <= 1'b0;
            in_ready       <= 1'b1;
            out_ctrl       <= CTRL_BUBBLE;
            out_ops        <= '0;
            out_regs       <= REGS_BUBBLE;
            out_write_reg  <= WR_BUBBLE;
            out_pc         <= '0;
            out_next_pc    <= '0;
            skid_ctrl      <= CTRL_BUBBLE;
            skid_ops       <= '0;
            skid_regs      <= REGS_BUBBLE;
            skid_write_reg <= WR_BUBBLE;
            skid_pc        <= '0;
            skid_next_pc   <= '0;
        end else if (flush) begin
            state          <= EMPTY;
            out_valid      <= 1'b0;
            in_ready       <= 1'b1;
            out_ctrl       <= CTRL_BUBBLE;
            out_regs       <= REGS_BUBBLE;
            out_write_reg  <= WR_BUBBLE;
            skid_ctrl      <= CTRL_BUBBLE;
            skid_regs      <= REGS_BUBBLE;
            skid_write_reg <= WR_BUBBLE;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state         <= ONE;
                        out_valid     <= 1'b1;
                        in_ready      <= 1'b1;
                        out_ctrl      <= in_ctrl;
                        out_ops       <= cap_ops;
                        out_regs      <= in_regs;
                        out_write_reg <= in_write_reg;
                        out_pc        <= in_pc;
                        out_next_pc   <= in_next_pc;
                    end
                end
                ONE: begin
                    if (accept && release_out) begin
                        state         <= ONE;
                        out_valid     <= 1'b1;
                        in_ready      <= 1'b1;
                        out_ctrl      <= in_ctrl;
                        out_ops       <= cap_ops;
                        out_regs      <= in_regs;
                        out_write_reg <= in_write_reg;
                        out_pc        <= in_pc;
                        out_next_pc   <= in_next_pc;
                    end else if (accept) begin
                        state          <= TWO;
                        in_ready       <= 1'b0;
                        skid_ctrl      <= in_ctrl;
                        skid_ops       <= cap_ops;
                        skid_regs      <= in_regs;
                        skid_write_reg <= in_write_reg;
                        skid_pc        <= in_pc;
                        skid_next_pc   <= in_next_pc;
                    end else if (release_out) begin
                        state         <= EMPTY;
                        out_valid     <= 1'b0;
                        in_ready      <= 1'b1;
                        out_ctrl      <= CTRL_BUBBLE;
                        out_regs      <= REGS_BUBBLE;
                        out_write_reg <= WR_BUBBLE;
                    end
                end
                TWO: begin
                    if (release_out) begin
                        state          <= ONE;
                        out_valid      <= 1'b1;
                        in_ready       <= 1'b1;
                        out_ctrl       <= skid_ctrl;
                        out_ops        <= skid_ops;
                        out_regs       <= skid_regs;
                        out_write_reg  <= skid_write_reg;
                        out_pc         <= skid_pc;
                        out_next_pc    <= skid_next_pc;
                        skid_ctrl      <= CTRL_BUBBLE;
                        skid_regs      <= REGS_BUBBLE;
                        skid_write_reg <= WR_BUBBLE;
                    end
                end
                default: begin
                    state         <= EMPTY;
                    out_valid     <= 1'b0;
                    in_ready      <= 1'b1;
                    out_ctrl      <= CTRL_BUBBLE;
                    out_regs      <= REGS_BUBBLE;
                    out_write_reg <= WR_BUBBLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: directed vector table, hand-written reset/flush/forward
// sequences and a randomized run against a queue-based FIFO model of the
// two-entry pipe stage. Define PIPE_STAGE_FWD_EN to also cover forwarding.
module tb_pipe_stage;

    localparam int DW = 32;
    localparam int CW = 16;
    localparam int NO = 2;
    localparam int RW = 5;

    typedef struct packed {
        logic [CW-1:0]    ctrl;
        logic [NO*DW-1:0] ops;
        logic [NO*RW-1:0] regs;
        logic [RW-1:0]    wr;
        logic [DW-1:0]    pc;
        logic [DW-1:0]    npc;
    } entry_t;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        ordy;
        logic        fl;
        logic        exp_valid;
        logic        exp_ready;
        logic [31:0] exp_pc;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [CW-1:0]    in_ctrl;
    logic [NO*DW-1:0] in_ops;
    logic [NO*RW-1:0] in_regs;
    logic [RW-1:0]    in_write_reg;
    logic [DW-1:0]    in_pc;
    logic [DW-1:0]    in_next_pc;
    logic             flush;
`ifdef PIPE_STAGE_FWD_EN
    logic [NO-1:0]    fwd_sel;
    logic [DW-1:0]    fwd_data;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_ctrl;
    logic [NO*DW-1:0] out_ops;
    logic [NO*RW-1:0] out_regs;
    logic [RW-1:0]    out_write_reg;
    logic [DW-1:0]    out_pc;
    logic [DW-1:0]    out_next_pc;

    int     tests = 0;
    int     fails = 0;
    entry_t model_q[$];
    vec_t   vecs[$];

    pipe_stage #(
        .DATA_W(DW), .CTRL_W(CW), .NUM_OPS(NO), .REG_W(RW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_ctrl      (in_ctrl),
        .in_ops       (in_ops),
        .in_regs      (in_regs),
        .in_write_reg (in_write_reg),
        .in_pc        (in_pc),
        .in_next_pc   (in_next_pc),
        .flush        (flush),
`ifdef PIPE_STAGE_FWD_EN
        .fwd_sel      (fwd_sel),
        .fwd_data     (fwd_data),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_ctrl     (out_ctrl),
        .out_ops      (out_ops),
        .out_regs     (out_regs),
        .out_write_reg(out_write_reg),
        .out_pc       (out_pc),
        .out_next_pc  (out_next_pc)
    );

    always #5 clk = ~clk;

    // Distinct, nonzero payload derived from the PC so any mix-up shows.
    function automatic entry_t mk_entry(input logic [31:0] pc);
        entry_t e;
        logic [4:0] r;
        r      = pc[6:2];
        e.ctrl = 16'h8000 | pc[15:0];
        e.ops  = {pc + 32'h2000, pc + 32'h1000};
        e.regs = {r + 5'd2, r + 5'd1};
        e.wr   = r ^ 5'h1F;
        e.pc   = pc;
        e.npc  = pc + 32'd4;
        return e;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic v, input entry_t e, input logic ordy, input logic fl);
        in_valid     = v;
        in_ctrl      = e.ctrl;
        in_ops       = e.ops;
        in_regs      = e.regs;
        in_write_reg = e.wr;
        in_pc        = e.pc;
        in_next_pc   = e.npc;
        out_ready    = ordy;
        flush        = fl;
`ifdef PIPE_STAGE_FWD_EN
        fwd_sel      = '0;
        fwd_data     = 32'hDEAD_BEEF;
`endif
    endtask

    function automatic entry_t dut_entry();
        return {out_ctrl, out_ops, out_regs, out_write_reg, out_pc, out_next_pc};
    endfunction

    task automatic check_output(input string name, input logic ev, input logic er, input entry_t ee);
        check({name, ".out_valid"}, 256'(out_valid), 256'(ev));
        check({name, ".in_ready"}, 256'(in_ready), 256'(er));
        if (ev)
            check({name, ".entry"}, 256'(dut_entry()), 256'(ee));
        else
            check({name, ".bubble"}, 256'({out_ctrl, out_regs, out_write_reg}), 256'(0));
    endtask

    // FIFO of capacity two: pop on release, push on accept, clear on flush.
    task automatic model_step();
        entry_t e;
        logic acc, rel;
        acc = in_valid && (model_q.size() < 2);
        rel = (model_q.size() > 0) && out_ready;
        e = '{ctrl: in_ctrl, ops: in_ops, regs: in_regs, wr: in_write_reg, pc: in_pc, npc: in_next_pc};
`ifdef PIPE_STAGE_FWD_EN
        for (int i = 0; i < NO; i++)
            if (fwd_sel[i]) e.ops[i*DW +: DW] = fwd_data;
`endif
        if (flush) begin
            model_q.delete();
        end else begin
            if (rel) void'(model_q.pop_front());
            if (acc) model_q.push_back(e);
        end
    endtask

    initial begin
        entry_t e;

        // Reset held with in_valid high: outputs stay idle throughout.
        rst = 1'b1;
        apply_stimulus(1'b1, mk_entry(32'h100), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output($sformatf("reset%0d", i), 1'b0, 1'b1, '0);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check_output("reset_release", 1'b0, 1'b1, '0);

        // Streaming, backpressure, flush-in-TWO and flush-in-ONE vectors.
        for (int i = 0; i < 8; i++)
            vecs.push_back('{1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b1, 1'b1, 32'(i * 4)});
        vecs.push_back('{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 32'h40, 1'b0, 1'b0, 1'b1, 1'b1, 32'h40});
        vecs.push_back('{1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40});
        vecs.push_back('{1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h40});
        vecs.push_back('{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b1, 32'h44});
        vecs.push_back('{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 32'h60, 1'b0, 1'b0, 1'b1, 1'b1, 32'h60});
        vecs.push_back('{1'b1, 32'h64, 1'b0, 1'b0, 1'b1, 1'b0, 32'h60});
        vecs.push_back('{1'b1, 32'h80, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h0});
        vecs.push_back('{1'b1, 32'h90, 1'b0, 1'b0, 1'b1, 1'b1, 32'h90});
        vecs.push_back('{1'b1, 32'h94, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0});
        vecs.push_back('{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 32'h0});
        foreach (vecs[i]) begin
            @(negedge clk);
            apply_stimulus(vecs[i].v, mk_entry(vecs[i].pc), vecs[i].ordy, vecs[i].fl);
            @(posedge clk);
            #1;
            check_output($sformatf("vec%0d_pc%0h", i, vecs[i].pc), vecs[i].exp_valid,
                         vecs[i].exp_ready, mk_entry(vecs[i].exp_pc));
        end

        // Reset in the middle of a full buffer discards both entries.
        @(negedge clk);
        apply_stimulus(1'b1, mk_entry(32'hA0), 1'b0, 1'b0);
        @(negedge clk);
        apply_stimulus(1'b1, mk_entry(32'hA4), 1'b0, 1'b0);
        @(negedge clk);
        check_output("full_before_reset", 1'b1, 1'b0, mk_entry(32'hA0));
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check_output("mid_reset", 1'b0, 1'b1, '0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_output("after_mid_reset", 1'b0, 1'b1, '0);

`ifdef PIPE_STAGE_FWD_EN
        // Forward operand 0 at accept; later fwd changes must not leak in.
        @(negedge clk);
        e = mk_entry(32'hC0);
        apply_stimulus(1'b1, e, 1'b0, 1'b0);
        in_ops   = {32'h22, 32'h11};
        fwd_sel  = 2'b01;
        fwd_data = 32'hAA;
        @(posedge clk);
        #1;
        check("fwd_op0", 256'(out_ops[31:0]), 256'(32'hAA));
        check("fwd_op1", 256'(out_ops[63:32]), 256'(32'h22));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            fwd_sel  = 2'b11;
            fwd_data = 32'h55;
            @(posedge clk);
            #1;
            check($sformatf("fwd_hold%0d", i), 256'(out_ops[31:0]), 256'(32'hAA));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("fwd_drain", 256'(out_valid), 256'(0));
`endif

        // Randomized traffic against the FIFO model.
        model_q.delete();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            e.ctrl = 16'($urandom);
            e.ops  = {$urandom, $urandom};
            e.regs = 10'($urandom);
            e.wr   = 5'($urandom);
            e.pc   = $urandom;
            e.npc  = $urandom;
            apply_stimulus(1'($urandom_range(0, 3) != 0), e, 1'($urandom_range(0, 2) != 0),
                           ($urandom_range(0, 15) == 0));
`ifdef PIPE_STAGE_FWD_EN
            fwd_sel  = 2'($urandom);
            fwd_data = $urandom;
`endif
            @(posedge clk);
            model_step();
            #1;
            check_output($sformatf("rand%0d", c), model_q.size() > 0, model_q.size() < 2,
                         (model_q.size() > 0) ? model_q[0] : '0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
